alu_seq_muldiv: RTL

//  Parametrised, handshaked execute unit for the multi-cycle RISC-V core. Extends the single-cycle
//  ALU op set with XOR, shifts, MUL/MULHU (iterative shift-add) and DIVU/REMU (iterative restoring).

---
 rtl/alu_seq_muldiv.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_muldiv.sv
// Handshaked execute unit: single-cycle ALU ops plus iterative MUL/MULHU and DIVU/REMU.
// Define ALU_DIV_EN to build the restoring divider; without it ops 12/13 behave as reserved.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic [3:0]         op_reg, op_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [3:0]         flags_reg, flags_next;

  logic [WIDTH:0]     add_sum, sub_sum;
  logic               add_v, sub_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_res;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     div_shift, div_diff;
`endif

  function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r[WIDTH-1], r == '0, c, v};
  endfunction

  // Single-cycle ops, evaluated on the operands present at the accept edge
  always_comb begin
    add_sum = {1'b0, src_a} + {1'b0, src_b};
    sub_sum = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    add_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_sum[WIDTH-1] != src_a[WIDTH-1]);
    sub_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_sum[WIDTH-1] != src_a[WIDTH-1]);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = add_sum[WIDTH-1:0]; alu_c = add_sum[WIDTH]; alu_v = add_v; end
      OP_SUB:  begin alu_res = sub_sum[WIDTH-1:0]; alu_c = sub_sum[WIDTH]; alu_v = sub_v; end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_v ^ sub_sum[WIDTH-1]};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sub_sum[WIDTH]};
      OP_SLL:  alu_res = src_a << src_b[SH_W-1:0];
      OP_SRL:  alu_res = src_a >> src_b[SH_W-1:0];
      OP_SRA:  alu_res = $signed(src_a) >>> src_b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // One iteration: acc = {partial/remainder, multiplier/dividend bits}
  always_comb begin
    mul_add  = acc_reg[0] ? opnd_reg : '0;
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    step_acc = {mul_sum, acc_reg[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (op_reg == OP_DIVU || op_reg == OP_REMU) begin
      if (div_diff[WIDTH])
        step_acc = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      else
        step_acc = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end
`endif
    step_res = (op_reg == OP_MUL || op_reg == OP_DIVU) ? step_acc[WIDTH-1:0]
                                                       : step_acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    op_next     = op_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next = op;
          if (op <= OP_SRA) begin
            result_next = alu_res;
            flags_next  = nzcv(alu_res, alu_c, alu_v);
            state_next  = DONE;
          end else if (op == OP_MUL || op == OP_MULHU) begin
            acc_next   = {{WIDTH{1'b0}}, src_b};
            opnd_next  = src_a;
            cnt_next   = CNT_W'(WIDTH - 1);
            state_next = BUSY;
`ifdef ALU_DIV_EN
          end else if ((op == OP_DIVU || op == OP_REMU) && src_b == '0) begin
            result_next = (op == OP_DIVU) ? '1 : src_a;
            flags_next  = nzcv(result_next, 1'b0, 1'b0);
            state_next  = DONE;
          end else if (op == OP_DIVU || op == OP_REMU) begin
            acc_next   = {{WIDTH{1'b0}}, src_a};
            opnd_next  = src_b;
            cnt_next   = CNT_W'(WIDTH - 1);
            state_next = BUSY;
`endif
          end else begin
            result_next = '0;
            flags_next  = 4'b0100;
            state_next  = DONE;
          end
        end
      end
      BUSY: begin
        acc_next = step_acc;
        if (cnt_reg == '0) begin
          result_next = step_res;
          flags_next  = nzcv(step_res, 1'b0, 1'b0);
          state_next  = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Redirect wins over everything, including a same-cycle accept
    if (flush) begin
      state_next  = IDLE;
      cnt_next    = '0;
      result_next = result_reg;
      flags_next  = flags_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule
